// File: rtl/regfile_hilo.sv
// Two-read / one-write 32x32 register file with HI/LO pair; R0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read outputs.
module regfile_hilo (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic        re1,
   input  logic [4:0]  raddr1,
   output logic [31:0] rdata1,
   input  logic        re2,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata2,
   input  logic        hilo_we,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   logic [31:0] regs [0:31];
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   // Entry 0 is cleared on reset and never written, so it stays zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
         end
         if (hilo_we) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
         end
      end
   end

   function automatic logic [31:0] read_port(input logic en, input logic [4:0] addr);
      logic [31:0] value;
      value = '0;
      if (!rst && en && (addr != 5'd0)) begin
         value = regs[addr];
`ifdef REGFILE_BYPASS_EN
         if (we && (waddr == addr)) begin
            value = wdata;
         end
`endif
      end
      return value;
   endfunction

   always_comb begin
      rdata1 = read_port(re1, raddr1);
      rdata2 = read_port(re2, raddr2);
   end

   always_comb begin
      hi_o = '0;
      lo_o = '0;
      if (!rst) begin
         hi_o = hi_q;
         lo_o = lo_q;
`ifdef REGFILE_BYPASS_EN
         if (hilo_we) begin
            hi_o = hi_i;
            lo_o = lo_i;
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo: stimulus pushes expectations, a negedge monitor checks them.
// Expected values follow the REGFILE_BYPASS_EN setting of the build.
module tb_regfile_hilo;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic        hilo_we;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] expected;
   } exp_t;

   exp_t sb[$];
   int   assertions = 0;
   int   failures = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   regfile_hilo dut (
      .clk(clk),
      .rst(rst),
      .we(we),
      .waddr(waddr),
      .wdata(wdata),
      .re1(re1),
      .raddr1(raddr1),
      .rdata1(rdata1),
      .re2(re2),
      .raddr2(raddr2),
      .rdata2(rdata2),
      .hilo_we(hilo_we),
      .hi_i(hi_i),
      .lo_i(lo_i),
      .hi_o(hi_o),
      .lo_o(lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: outputs are combinational, so every pending expectation is checked mid-cycle.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [31:0] actual;
         e = sb.pop_front();
         case (e.sel)
            0:       actual = rdata1;
            1:       actual = rdata2;
            2:       actual = hi_o;
            default: actual = lo_o;
         endcase
         assertions++;
         if (actual !== e.expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, actual, e.expected);
         end
      end
   end

   task automatic applyStimulus(
      input logic        r,
      input logic        w,
      input logic [4:0]  wa,
      input logic [31:0] wd,
      input logic        e1,
      input logic [4:0]  a1,
      input logic        e2,
      input logic [4:0]  a2,
      input logic        hw,
      input logic [31:0] hv,
      input logic [31:0] lv
   );
      @(posedge clk);
      #1;
      rst = r; we = w; waddr = wa; wdata = wd;
      re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
      hilo_we = hw; hi_i = hv; lo_i = lv;
   endtask

   task automatic checkOutput(input string name, input int sel, input logic [31:0] expected);
      exp_t e;
      e.name = name;
      e.sel = sel;
      e.expected = expected;
      sb.push_back(e);
   endtask

   initial begin
      int wait_cycles;
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
      hilo_we = 1'b0; hi_i = '0; lo_i = '0;

      // Reset held two cycles with a write pending
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 1, 5'd5, 32'h12345678, 1, 5'd5, 1, 5'd5, 1, 32'hAAAA5555, 32'h5555AAAA);
         checkOutput("rst_rdata1", 0, 32'h0);
         checkOutput("rst_rdata2", 1, 32'h0);
         checkOutput("rst_hi", 2, 32'h0);
         checkOutput("rst_lo", 3, 32'h0);
      end
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd5, 0, 32'h0, 32'h0);
      checkOutput("post_rst_r5", 0, 32'h0);
      checkOutput("post_rst_re2_off", 1, 32'h0);
      checkOutput("post_rst_hi", 2, 32'h0);
      checkOutput("post_rst_lo", 3, 32'h0);

      // R0 write must be ignored, including by forwarding
      applyStimulus(0, 1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0);
      checkOutput("r0_same_cycle", 0, 32'h0);
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0);
      checkOutput("r0_after", 0, 32'h0);

      // Dual read
      applyStimulus(0, 1, 5'd3, 32'h0000AAAA, 0, 5'd3, 0, 5'd0, 0, 32'h0, 32'h0);
      checkOutput("re1_off", 0, 32'h0);
      applyStimulus(0, 1, 5'd7, 32'h5555FFFF, 1, 5'd3, 0, 5'd0, 0, 32'h0, 32'h0);
      checkOutput("r3_while_writing_r7", 0, 32'h0000AAAA);
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd3, 1, 5'd7, 0, 32'h0, 32'h0);
      checkOutput("dual_r3", 0, 32'h0000AAAA);
      checkOutput("dual_r7", 1, 32'h5555FFFF);
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd7, 0, 32'h0, 32'h0);
      checkOutput("dual_r3_again", 0, 32'h0000AAAA);
      checkOutput("re2_off", 1, 32'h0);
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd7, 0, 32'h0, 32'h0);
      checkOutput("same_addr_p1", 0, 32'h5555FFFF);
      checkOutput("same_addr_p2", 1, 32'h5555FFFF);

      // Write/read of the same register in one cycle
      applyStimulus(0, 1, 5'd9, 32'hCAFEF00D, 1, 5'd9, 1, 5'd3, 0, 32'h0, 32'h0);
      checkOutput("bypass_r9", 0, BYPASS ? 32'hCAFEF00D : 32'h0);
      checkOutput("unrelated_r3", 1, 32'h0000AAAA);
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd0, 0, 32'h0, 32'h0);
      checkOutput("r9_next", 0, 32'hCAFEF00D);

      // Top register boundary
      applyStimulus(0, 1, 5'd31, 32'h80000001, 0, 5'd0, 1, 5'd31, 0, 32'h0, 32'h0);
      checkOutput("r31_same_cycle", 1, BYPASS ? 32'h80000001 : 32'h0);
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd31, 1, 5'd9, 0, 32'h0, 32'h0);
      checkOutput("r31_next", 0, 32'h80000001);
      checkOutput("r9_kept", 1, 32'hCAFEF00D);

      // HI/LO
      applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 1, 32'h00000001, 32'hFFFFFFFE);
      checkOutput("hi_same_cycle", 2, BYPASS ? 32'h00000001 : 32'h0);
      checkOutput("lo_same_cycle", 3, BYPASS ? 32'hFFFFFFFE : 32'h0);
      applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 0, 32'h0000ABCD, 32'h00001234);
      checkOutput("hi_held", 2, 32'h00000001);
      checkOutput("lo_held", 3, 32'hFFFFFFFE);

      // Reset mid-operation
      applyStimulus(0, 1, 5'd4, 32'h11111111, 0, 5'd0, 0, 5'd0, 0, 32'h0, 32'h0);
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd0, 0, 32'h0, 32'h0);
      checkOutput("r4_before_rst", 0, 32'h11111111);
      applyStimulus(1, 1, 5'd4, 32'h22222222, 1, 5'd4, 0, 5'd0, 1, 32'h77777777, 32'h88888888);
      checkOutput("mid_rst_rdata1", 0, 32'h0);
      checkOutput("mid_rst_hi", 2, 32'h0);
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd4, 1, 5'd9, 0, 32'h0, 32'h0);
      checkOutput("r4_after_rst", 0, 32'h0);
      checkOutput("r9_cleared", 1, 32'h0);
      checkOutput("hi_cleared", 2, 32'h0);
      checkOutput("lo_cleared", 3, 32'h0);
      applyStimulus(0, 1, 5'd4, 32'h33333333, 1, 5'd4, 0, 5'd0, 0, 32'h0, 32'h0);
      checkOutput("first_write_same", 0, BYPASS ? 32'h33333333 : 32'h0);
      applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd0, 0, 32'h0, 32'h0);
      checkOutput("first_write_next", 0, 32'h33333333);

      wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (sb.size() > 0) begin
         assertions++;
         failures++;
         $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
